sd_window_engine: RTL

//  Parametrised successor to the 48-bit stereo MAC engine. Accepts left/right pixel rows and computes
//  per-pixel SSD (squared diff) or SAD (abs diff), LANES pixels per cycle. Accumulates across rows

---
 rtl/stereo_pkg.sv | 24 ++
 rtl/sd_lane.sv | 22 ++
 rtl/sd_window_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
// Shared types and sizing helper for the stereo window-cost datapath.
// Cost mode, engine state and accumulator width derivation.
package stereo_pkg;

    typedef enum logic {
        SD_SSD = 1'b0,
        SD_SAD = 1'b1
    } sd_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } sd_state_e;

    // Bits needed to hold max_rows full-scale squared-diff rows.
    function automatic int sd_acc_w(int pix_w, int num_pix, int max_rows);
        longint m;
        m = (longint'(1) << pix_w) - 1;
        return $clog2(longint'(max_rows) * num_pix * m * m + 1);
    endfunction

endpackage

// File: rtl/sd_lane.sv
// One pixel-pair lane: absolute difference, optionally squared.
// Purely combinational; the engine instantiates one per lane.
module sd_lane #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0]   i_l,
    input  logic [PIX_W-1:0]   i_r,
    input  logic               i_sad,
    output logic [2*PIX_W-1:0] o_val
);

    logic [PIX_W-1:0]   w_d;
    logic [2*PIX_W-1:0] w_dx;

    // |L-R| widened, then squared unless SAD is selected
    always_comb begin
        w_d   = (i_l >= i_r) ? (i_l - i_r) : (i_r - i_l);
        w_dx  = {{PIX_W{1'b0}}, w_d};
        o_val = i_sad ? w_dx : (w_dx * w_dx);
    end

endmodule

// File: rtl/sd_window_engine.sv
// Stereo window cost engine: per-row SSD/SAD over LANES-wide chunks,
// accumulated with saturation until a row marked last.
module sd_window_engine
    import stereo_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int NUM_PIX  = 6,
    parameter int LANES    = 2,
    parameter int MAX_ROWS = 1,
    localparam int ACC_W   = sd_acc_w(PIX_W, NUM_PIX, MAX_ROWS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_PIX*PIX_W-1:0] left_row,
    input  logic [NUM_PIX*PIX_W-1:0] right_row,
    input  logic                     last_in,
    input  logic                     mode_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [ACC_W-1:0]         result_out,
    output logic                     sat_out,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam int CHUNKS = NUM_PIX / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PSUM_W = 2 * PIX_W + $clog2(LANES) + 1;
    localparam int SUM_W  = ACC_W + 1;

    sd_state_e                           r_state;
    sd_mode_e                            r_mode;
    logic                                r_first;
    logic                                r_last;
    logic [CW-1:0]                       r_chunk;
    logic [CHUNKS-1:0][LANES*PIX_W-1:0]  r_left;
    logic [CHUNKS-1:0][LANES*PIX_W-1:0]  r_right;
    logic [PSUM_W-1:0]                   r_psum;
    logic                                r_psum_v;
    logic [ACC_W-1:0]                    r_acc;
    logic                                r_sat;
    logic                                r_valid;

    logic [LANES*PIX_W-1:0]  w_lsel;
    logic [LANES*PIX_W-1:0]  w_rsel;
    logic [2*PIX_W-1:0]      w_val [LANES];
    logic [PSUM_W-1:0]       w_psum;
    logic [SUM_W-1:0]        w_sum;

    assign w_lsel = r_left[r_chunk];
    assign w_rsel = r_right[r_chunk];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sd_lane #(.PIX_W(PIX_W)) u_lane (
            .i_l   (w_lsel[g*PIX_W +: PIX_W]),
            .i_r   (w_rsel[g*PIX_W +: PIX_W]),
            .i_sad (r_mode == SD_SAD),
            .o_val (w_val[g])
        );
    end

    // Lane values summed, and the widened accumulator candidate
    always_comb begin
        w_psum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_psum = w_psum + PSUM_W'(w_val[i]);
        end
        w_sum = {1'b0, r_acc} + SUM_W'(r_psum);
    end

    // FSM, chunk counter, psum pipeline and saturating accumulator
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state  <= IDLE;
            r_mode   <= SD_SSD;
            r_first  <= 1'b1;
            r_last   <= 1'b0;
            r_chunk  <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_psum   <= '0;
            r_psum_v <= 1'b0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_psum_v <= 1'b0;
            if (r_psum_v) begin
                if (w_sum[ACC_W]) begin
                    r_acc <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_left  <= left_row;
                        r_right <= right_row;
                        r_last  <= last_in;
                        if (r_first) begin
                            r_mode <= sd_mode_e'(mode_in);
                        end
                        r_first <= 1'b0;
                        r_chunk <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_psum   <= w_psum;
                    r_psum_v <= 1'b1;
                    if (r_chunk == CW'(CHUNKS - 1)) begin
                        r_state <= FLUSH;
                    end else begin
                        r_chunk <= r_chunk + CW'(1);
                    end
                end
                FLUSH: begin
                    if (r_last) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_mode  <= SD_SSD;
                        r_first <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ready_out    = (r_state == IDLE) && rst_in;
    assign result_out   = r_acc;
    assign sat_out      = r_sat;
    assign result_valid = r_valid;

endmodule
